// File: rtl/digitube_scan_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : digitube_scan_drv                                          |
// | Description : 4-digit multiplexed 7-segment scan driver with a shadow    |
// |               register so new contents only appear at a frame boundary.  |
// |               Define DIGITUBE_LZ_BLANK_EN for leading-zero blanking.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module digitube_scan_drv #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    input  logic        enable,
    output logic [11:0] digi_out,
    output logic        frame_start,
    output logic        pending
);

    localparam logic [15:0] c_cnt_max   = 16'(SCAN_DIV - 1);
    localparam logic [11:0] c_blank_out = 12'h0FF;

    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_shadow_data;
    logic [3:0]  r_shadow_dp;
    logic [15:0] r_active_data;
    logic [3:0]  r_active_dp;
    logic        r_pending;
    logic        r_frame_start;
    logic [11:0] r_digi_out;

    logic        w_tick;
    logic        w_wrap;
    logic [3:0]  w_nibble;
    logic        w_dp_bit;
    logic [3:0]  w_an;
    logic [6:0]  w_seg;
    logic [6:0]  w_seg_out;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign w_tick = (r_cnt == c_cnt_max);
    assign w_wrap = w_tick && (r_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Active only moves at a wrap and always takes the pre-edge shadow, so a
    // write landing on the wrap edge is held over for the following frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_active_data <= '0;
            r_active_dp   <= '0;
            r_pending     <= 1'b0;
        end else begin
            if (w_wrap && r_pending) begin
                r_active_data <= r_shadow_data;
                r_active_dp   <= r_shadow_dp;
            end
            if (wr_en) begin
                r_shadow_data <= wr_data;
                r_shadow_dp   <= wr_dp;
                r_pending     <= 1'b1;
            end else if (w_wrap) begin
                r_pending     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
        end
    end

    assign w_nibble = r_active_data[{r_idx, 2'b00} +: 4];
    assign w_dp_bit = r_active_dp[r_idx];
    assign w_an     = 4'b0001 << r_idx;
    assign w_seg    = hex_to_seg(w_nibble);

`ifdef DIGITUBE_LZ_BLANK_EN
    logic w_lz_blank;

    // A digit is a leading zero when it and every more significant nibble is 0.
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_idx)
            2'd1:    w_lz_blank = (r_active_data[15:4]  == 12'h000);
            2'd2:    w_lz_blank = (r_active_data[15:8]  == 8'h00);
            2'd3:    w_lz_blank = (r_active_data[15:12] == 4'h0);
            default: w_lz_blank = 1'b0;
        endcase
    end

    assign w_seg_out = w_lz_blank ? 7'h7F : w_seg;
`else
    assign w_seg_out = w_seg;
`endif

    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            r_digi_out <= c_blank_out;
        end else begin
            r_digi_out <= {w_an, ~w_dp_bit, w_seg_out};
        end
    end

    assign digi_out    = r_digi_out;
    assign frame_start = r_frame_start;
    assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_digitube_scan_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_digitube_scan_drv                                       |
// | Description : Scoreboard bench for digitube_scan_drv (SCAN_DIV = 4).     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_digitube_scan_drv;

    localparam int D     = 4;
    localparam int FRAME = 4 * D;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp = '0;
    logic        enable = 1'b1;
    logic [11:0] digi_out;
    logic        frame_start;
    logic        pending;

    digitube_scan_drv #(.SCAN_DIV(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .enable      (enable),
        .digi_out    (digi_out),
        .frame_start (frame_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] out;
        logic        fs;
        logic        pend;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference: edges since reset give the slot and frame position directly.
    int          k;
    logic [15:0] m_show_d;
    logic [3:0]  m_show_dp;
    logic [15:0] m_q_d;
    logic [3:0]  m_q_dp;
    bit          m_qv;
    logic        cur_en = 1'b1;

    function automatic logic [11:0] expect_out(input logic [15:0] data, input logic [3:0] dp,
                                               input int slot);
        logic [6:0] seg;
        int         nib;
        nib = int'((data >> (4 * slot)) & 16'h000F);
        seg = seg_tab[nib];
`ifdef DIGITUBE_LZ_BLANK_EN
        if (slot > 0 && (data >> (4 * slot)) == 16'h0000) seg = 7'h7F;
`endif
        return {4'(1 << slot), ~dp[slot], seg};
    endfunction

    task automatic step(input logic rst_n, input logic we, input logic [15:0] d,
                        input logic [3:0] p, input logic en);
        exp_t e;
        @(negedge clk);
        reset = rst_n; wr_en = we; wr_data = d; wr_dp = p; enable = en;
        if (!rst_n) begin
            k = 0; m_show_d = '0; m_show_dp = '0; m_q_d = '0; m_q_dp = '0; m_qv = 0;
            e.out = 12'h0FF; e.fs = 1'b0; e.pend = 1'b0;
        end else begin
            k++;
            e.out = en ? expect_out(m_show_d, m_show_dp, ((k - 1) / D) % 4) : 12'h0FF;
            e.fs  = (k % FRAME == 0);
            if (e.fs && m_qv) begin
                m_show_d = m_q_d; m_show_dp = m_q_dp; m_qv = 0;
            end
            if (we) begin
                m_q_d = d; m_q_dp = p; m_qv = 1;
            end
            e.pend = m_qv;
        end
        e.cyc = k;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 4'h0, cur_en);
    endtask

    // Idle until the next edge lands at frame position pos (pos 0 = wrap edge).
    task automatic align(input int pos);
        for (int i = 0; i < FRAME && ((k + 1) % FRAME) != pos; i++) idle(1);
    endtask

    task automatic chk(input string name, input int cyc, input logic [11:0] got,
                       input logic [11:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("digi_out", e.cyc, digi_out, e.out);
                chk("frame_start", e.cyc, 12'(frame_start), 12'(e.fs));
                chk("pending", e.cyc, 12'(pending), 12'(e.pend));
            end
        end
    end

    initial begin : driver
        logic [15:0] rd;
        step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);

        idle(2 * FRAME);

        align(6);
        step(1'b1, 1'b1, 16'h12AF, 4'b0001, cur_en);
        idle(2 * FRAME);

        align(3);
        step(1'b1, 1'b1, 16'h1111, 4'b0000, cur_en);
        idle(2);
        step(1'b1, 1'b1, 16'h2222, 4'b0000, cur_en);
        idle(2 * FRAME);

        align(4);
        step(1'b1, 1'b1, 16'h2222, 4'b0000, cur_en);
        align(0);
        step(1'b1, 1'b1, 16'h3333, 4'b1010, cur_en);
        idle(3 * FRAME);

        align(5);
        cur_en = 1'b0;
        idle(FRAME + 3);
        cur_en = 1'b1;
        idle(FRAME);

        align(7);
        step(1'b1, 1'b1, 16'h0005, 4'b0000, cur_en);
        idle(2 * FRAME);

        align(9);
        step(1'b1, 1'b1, 16'hABCD, 4'b1111, cur_en);
        idle(3);
        step(1'b0, 1'b0, 16'h0, 4'h0, cur_en);
        idle(FRAME + 4);

        for (int i = 0; i < 800; i++) begin
            rd = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0), rd,
                 4'($urandom), ($urandom_range(0, 9) != 0));
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", k, 12'(sb.size()), 12'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digitube_scan_drv.md
DIGITUBE_SCAN_DRV -- requirements
Module: digitube_scan_drv

Interface
REQ-001 Parameter SCAN_DIV, default 50000, SHALL set the clock cycles per digit slot; legal range 2..65535.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-004 wr_en  input  1  SHALL be a one-cycle write strobe for new display contents.
REQ-005 wr_data  input  16  SHALL carry four hex digits; [3:0] is digit 0 and [15:12] is digit 3.
REQ-006 wr_dp  input  4  SHALL carry the decimal points; bit i is digit i, 1 = lit.
REQ-007 enable  input  1  SHALL select display on (1) or blanked (0).
REQ-008 digi_out  output  12  SHALL be {AN3,AN2,AN1,AN0,DP,CG,CF,CE,CD,CC,CB,CA}; AN is one-hot active-high; DP and segments are active-low.
REQ-009 frame_start  output  1  SHALL pulse for one cycle at each frame wrap.
REQ-010 pending  output  1  SHALL be high while written data is waiting to be displayed.

Function
REQ-011 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap; tick = (cnt == SCAN_DIV-1).
REQ-012 Digit index idx SHALL advance by 1 on each tick, wrapping from 3 to 0; wrap = tick with idx==3.
REQ-013 A wr_en SHALL load wr_data/wr_dp into a shadow register and set pending on the same edge.
REQ-014 Repeated wr_en while pending SHALL overwrite the shadow register (last write wins).
REQ-015 On wrap with pending=1, the active register SHALL load from shadow and pending SHALL clear, unless wr_en is also high.
REQ-016 If wr_en coincides with a wrap, active SHALL take the pre-edge shadow, shadow SHALL take the new data, and pending SHALL stay 1.
REQ-017 The display SHALL never change mid-frame; the active register changes only at a wrap.
REQ-018 frame_start SHALL be registered high for exactly the cycle following each wrap edge.
REQ-019 digi_out SHALL be registered from idx/active with one cycle of latency: AN = 1<<idx, DP = ~dp[idx], segments = hex decode of the nibble.
REQ-020 Hex decode SHALL be active-low standard 0-F; anchors: 0=7'b1000000, 1=7'b1111001, 5=7'b0010010, 8=7'b0000000, A=7'b0001000, F=7'b0001110.
REQ-021 With enable=0, digi_out SHALL be 12'h0FF from the next cycle. cnt, idx, frame_start and the write path SHALL keep running.

Reset
REQ-022 With reset low at a clock edge, cnt, idx, active, shadow, wr_dp copies, pending and frame_start SHALL clear to 0, and digi_out SHALL become 12'h0FF.
REQ-023 Reset mid-frame or with pending=1 SHALL discard the shadow contents. The first enabled output after release SHALL be 12'h1C0 (digit 0 showing '0').

Configuration
REQ-024 Macro DIGITUBE_LZ_BLANK_EN defined SHALL enable leading-zero blanking, as set out in REQ-025 and REQ-026.
REQ-025 A digit 3..1 whose nibble and all higher nibbles are zero SHALL output segments 7'h7F, with AN still asserted and DP still per wr_dp.
REQ-026 Digit 0 SHALL never be blanked.
REQ-027 Without DIGITUBE_LZ_BLANK_EN, all four digits SHALL always be decoded.

Verification (SCAN_DIV=4)
REQ-028 Reset, enable=1, no writes -> digi_out cycles 12'h1C0, 2C0, 4C0, 8C0, each held 4 cycles; frame_start pulses every 16 cycles.
REQ-029 Mid-frame write 16'h12AF with dp 4'b0001 -> pending=1, display unchanged until wrap; next frame shows digit0=12'h10E and digit3=12'h8F9; pending clears at the wrap.
REQ-030 Writes 16'h1111 then 16'h2222 in one frame -> only 16'h2222 is displayed, e.g. digit0=12'h1A4.
REQ-031 wr_en of 16'h3333 on the wrap edge, with the earlier shadow holding 16'h2222 -> that frame shows 2222, pending stays 1, and 3333 appears one frame later.
REQ-032 enable dropped to 0 -> digi_out=12'h0FF one cycle later, frame_start continues; enable raised -> resumes at the current idx.
REQ-033 Write 16'h0005 -> digit0=12'h192; digit1=12'h2FF with the macro, 12'h2C0 without it.
